mult_dot_accumulator: RTL and testbench
=======================================

// Module: mult_dot_accumulator
// PURPOSE
//   Sequencer/accumulator directly upstream and downstream of the signed
//   streamlined multiplier. Accepts signed operand pairs on a valid/ready
//   stream and pulses the multiplier's start. Waits for the multiplier's
//   ready, then sign-extends and saturating-adds each product into an
//   accumulator. On the pair flagged last, presents the dot product on a
//   valid/ready output.
// PARAMETERS
//   WIDTH      8   operand width; must match the multiplier (2..16)
//   ACC_WIDTH  24  accumulator width (>= 2*WIDTH)
//   CNT_WIDTH  8   element counter width
// PORTS
//   clk        in   1            rising-edge clock
//   rst        in   1            synchronous active-high reset
//   in_a       in   WIDTH        signed operand A
//   in_b       in   WIDTH        signed operand B
//   in_last    in   1            pair is the final element of the vector
//   in_valid   in   1            operand pair valid
//   in_ready   out  1            block can accept a pair
//   mul_a      out  WIDTH        to multiplier ina (registered)
//   mul_b      out  WIDTH        to multiplier inb (registered)
//   mul_start  out  1            to multiplier start (one-cycle pulse)
//   mul_out    in   2*WIDTH      from multiplier out (signed product)
//   mul_ready  in   1            from multiplier ready
//   out_acc    out  ACC_WIDTH    signed dot-product result
//   out_count  out  CNT_WIDTH    number of products accumulated
//   out_sat    out  1            sticky: saturation occurred in this vector
//   out_err    out  1            multiplier timeout occurred
//   out_valid  out  1            result valid
//   out_ready  in   1            consumer accepts result
// BEHAVIOUR
//   Reset (sync, rst=1 at posedge):
//   - state=IDLE; all outputs 0 except in_ready=1; acc and count cleared.
//   - Reset mid-operation abandons the vector. The multiplier has no reset
//     and may finish; its stale ready is ignored, because every operation
//     issues start before mul_ready is sampled.
//   FSM:
//   - IDLE: in_ready=1. On in_valid: latch mul_a/mul_b/last_r -> ISSUE.
//   - ISSUE: mul_start=1 for exactly one cycle; clear wait counter -> WAIT.
//   - WAIT: mul_a/mul_b stay stable. mul_ready is sampled only here.
//     On mul_ready=1: acc += sext(mul_out); count += 1.
//     Then -> DONE if last_r, else -> IDLE.
//   - WAIT timeout: if the wait counter reaches WIDTH+4 without mul_ready,
//     set out_err=1 and go to DONE with the partial acc.
//   - DONE: out_valid=1; out_acc/out_count/out_sat/out_err held stable.
//     On out_ready: clear acc, count, sat, err -> IDLE.
//   Timing:
//   - Accept at posedge t; start sampled at t+1; multiplier ready at
//     t+1+WIDTH; accumulate at t+2+WIDTH.
//   - in_ready is high again the cycle after posedge t+2+WIDTH.
//   - Throughput: one pair per WIDTH+3 cycles, including the IDLE cycle.
//   - For a last pair, out_valid rises after posedge t+2+WIDTH.
//   Arithmetic:
//   - mul_out is sign-extended to ACC_WIDTH+1 before the add.
//   - Result > max clamps to 2^(ACC_WIDTH-1)-1; result < min clamps to
//     -2^(ACC_WIDTH-1). Either case sets out_sat.
//   - count wraps modulo 2^CNT_WIDTH; wrap is not flagged.
//   Handshake:
//   - No input is accepted outside IDLE, so in_ready=0 while DONE is
//     stalled by out_ready=0.
//   - out_valid must not drop until accepted.
// TESTING (WIDTH=8, ACC_WIDTH=24 unless noted)
//   1. Single pair (3,-5,last) -> out_acc=-15, count=1, out_valid 10 cycles after accept.
//   2. Four pairs (127,127), last on 4th -> out_acc=64516, count=4, sat=0.
//   3. ACC_WIDTH=16, three pairs (127,127) -> out_acc=32767, sat=1; (-128,127)x3 -> -32768, sat=1.
//   4. out_ready low 5 cycles in DONE -> outputs held, in_ready=0; after accept acc=0, next vector (2,2,last) -> 4.
//   5. rst pulsed mid-WAIT -> all outputs reset; then (-2,-64,last) -> out_acc=128, err=0.
//   6. Multiplier model with mul_ready stuck 0 -> out_err=1, out_valid=1 after WIDTH+4 WAIT cycles.

Source files
------------

// File: rtl/mult_dot_accumulator.sv
// rtl/mult_dot_accumulator.sv - sequencer and saturating accumulator around a signed multiplier
module mult_dot_accumulator #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    input  logic                   in_last,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    output logic                   mul_start,
    input  logic [2*WIDTH-1:0]     mul_out,
    input  logic                   mul_ready,
    output logic [ACC_WIDTH-1:0]   out_acc,
    output logic [CNT_WIDTH-1:0]   out_count,
    output logic                   out_sat,
    output logic                   out_err,
    output logic                   out_valid,
    input  logic                   out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The wait counter must hold WIDTH+3, the last count before timing out.
    localparam int WAIT_W = $clog2(WIDTH + 5);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WIDTH + 3);

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t              state;
    logic                last_r;
    logic [WAIT_W-1:0]   wait_cnt;

    logic [ACC_WIDTH:0]   prod_ext;
    logic [ACC_WIDTH:0]   acc_ext;
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 sat_hit;

    // One guard bit above the accumulator; a mismatch between the top two sum bits is overflow.
    always_comb begin
        prod_ext = {{(ACC_WIDTH+1-2*WIDTH){mul_out[2*WIDTH-1]}}, mul_out};
        acc_ext  = {out_acc[ACC_WIDTH-1], out_acc};
        sum      = acc_ext + prod_ext;
        sat_hit  = 1'b0;
        acc_next = sum[ACC_WIDTH-1:0];
        if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            sat_hit  = 1'b1;
            acc_next = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end

    // Control FSM with all handshake and result outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_start <= 1'b0;
            out_acc   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
            out_err   <= 1'b0;
            out_valid <= 1'b0;
            last_r    <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mul_a     <= in_a;
                        mul_b     <= in_b;
                        last_r    <= in_last;
                        in_ready  <= 1'b0;
                        mul_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_start <= 1'b0;
                    wait_cnt  <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // Start was issued a cycle ago, so any ready seen here belongs to this operation.
                    if (mul_ready) begin
                        out_acc   <= acc_next;
                        out_sat   <= out_sat | sat_hit;
                        out_count <= out_count + CNT_WIDTH'(1);
                        if (last_r) begin
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            in_ready  <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt  <= wait_cnt + WAIT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_acc   <= '0;
                        out_count <= '0;
                        out_sat   <= 1'b0;
                        out_err   <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_dot_accumulator.sv
// tb/tb_mult_dot_accumulator.sv - randomized self-checking bench for mult_dot_accumulator
module tb_mult_dot_accumulator;

    localparam int WIDTH = 8;
    localparam int AW0   = 24;
    localparam int AW1   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        stuck = 1'b0;

    logic        in_ready[2];
    logic [7:0]  mul_a[2];
    logic [7:0]  mul_b[2];
    logic        mul_start[2];
    logic [15:0] mul_out[2];
    logic        mul_ready[2];
    logic [7:0]  out_count[2];
    logic        out_sat[2];
    logic        out_err[2];
    logic        out_valid[2];
    logic [AW0-1:0] out_acc0;
    logic [AW1-1:0] out_acc1;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int va[300];
    int vb[300];

    int                 m_cnt[2]  = '{0, 0};
    logic               m_rdy[2]  = '{1'b1, 1'b1};
    logic signed [15:0] m_prod[2] = '{16'sd0, 16'sd0};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mult_dot_accumulator #(.WIDTH(WIDTH), .ACC_WIDTH(AW0), .CNT_WIDTH(8)) dut0 (
        .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready[0]), .mul_a(mul_a[0]), .mul_b(mul_b[0]),
        .mul_start(mul_start[0]), .mul_out(mul_out[0]), .mul_ready(mul_ready[0]),
        .out_acc(out_acc0), .out_count(out_count[0]), .out_sat(out_sat[0]),
        .out_err(out_err[0]), .out_valid(out_valid[0]), .out_ready(out_ready)
    );

    mult_dot_accumulator #(.WIDTH(WIDTH), .ACC_WIDTH(AW1), .CNT_WIDTH(8)) dut1 (
        .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready[1]), .mul_a(mul_a[1]), .mul_b(mul_b[1]),
        .mul_start(mul_start[1]), .mul_out(mul_out[1]), .mul_ready(mul_ready[1]),
        .out_acc(out_acc1), .out_count(out_count[1]), .out_sat(out_sat[1]),
        .out_err(out_err[1]), .out_valid(out_valid[1]), .out_ready(out_ready)
    );

    // Behavioural multiplier: product ready WIDTH cycles after start, garbage on the bus until then.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mul_start[k]) begin
                m_cnt[k]  <= WIDTH;
                m_rdy[k]  <= 1'b0;
                m_prod[k] <= $signed(mul_a[k]) * $signed(mul_b[k]);
            end else if (m_cnt[k] > 1) begin
                m_cnt[k]  <= m_cnt[k] - 1;
            end else if (m_cnt[k] == 1) begin
                m_cnt[k]  <= 0;
                m_rdy[k]  <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            mul_ready[k] = m_rdy[k] & ~stuck;
            mul_out[k]   = m_rdy[k] ? m_prod[k] : 16'hdead;
        end
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint get_acc(input int k);
        if (k == 0) return longint'($signed(out_acc0));
        return longint'($signed(out_acc1));
    endfunction

    // Reference: saturating running sum of a*b over the vector, excluding a timed-out final pair.
    function automatic void ref_vec(input int n, input int aw, input bit stuck_last,
                                    output longint acc, output int cnt, output bit sat);
        longint mx, mn;
        int used;
        mx   = (longint'(1) << (aw - 1)) - 1;
        mn   = -(longint'(1) << (aw - 1));
        used = stuck_last ? n - 1 : n;
        acc  = 0;
        sat  = 1'b0;
        for (int i = 0; i < used; i++) begin
            acc = acc + longint'(va[i]) * longint'(vb[i]);
            if (acc > mx) begin acc = mx; sat = 1'b1; end
            if (acc < mn) begin acc = mn; sat = 1'b1; end
        end
        cnt = used % 256;
    endfunction

    task automatic check_idle(input string tag);
        for (int k = 0; k < 2; k++) begin
            check_eq({tag, "_valid"}, out_valid[k], 0);
            check_eq({tag, "_acc"}, get_acc(k), 0);
            check_eq({tag, "_count"}, out_count[k], 0);
            check_eq({tag, "_sat"}, out_sat[k], 0);
            check_eq({tag, "_err"}, out_err[k], 0);
            check_eq({tag, "_in_ready"}, in_ready[k], 1);
        end
    endtask

    // Stream va/vb[0..n-1], check issue/timing, result and stall behaviour, then accept.
    task automatic send_vec(input int n, input bit stuck_last, input int stall);
        int acc_cyc, prev_cyc, b, s;
        longint e_acc;
        int e_cnt;
        bit e_sat;
        prev_cyc = 0;
        acc_cyc  = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            b = 0;
            while (!in_ready[0] && b < 50) begin
                @(negedge clk);
                b++;
            end
            if (b >= 50) check_eq("in_ready_timeout", 0, 1);
            if (i == n - 1 && stuck_last) stuck = 1'b1;
            in_a     = va[i][7:0];
            in_b     = vb[i][7:0];
            in_last  = (i == n - 1);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            acc_cyc  = cyc;
            if (i > 0) check_eq("accept_interval", acc_cyc - prev_cyc, WIDTH + 3);
            prev_cyc = acc_cyc;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                check_eq("mul_start", mul_start[k], 1);
                check_eq("mul_a", longint'($signed(mul_a[k])), va[i]);
                check_eq("mul_b", longint'($signed(mul_b[k])), vb[i]);
            end
        end
        b = 0;
        while (!out_valid[0] && b < 40) begin
            @(negedge clk);
            b++;
        end
        check_eq("out_valid_latency", cyc - acc_cyc, stuck_last ? WIDTH + 5 : WIDTH + 2);
        s = (stall < 0) ? int'($urandom_range(0, 5)) : stall;
        for (int j = 0; j <= s; j++) begin
            for (int k = 0; k < 2; k++) begin
                ref_vec(n, (k == 0) ? AW0 : AW1, stuck_last, e_acc, e_cnt, e_sat);
                check_eq("done_valid", out_valid[k], 1);
                check_eq("done_in_ready", in_ready[k], 0);
                check_eq("done_acc", get_acc(k), e_acc);
                check_eq("done_count", out_count[k], e_cnt);
                check_eq("done_sat", out_sat[k], e_sat);
                check_eq("done_err", out_err[k], stuck_last);
            end
            if (j < s) @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        stuck     = 1'b0;
        @(negedge clk);
        check_idle("after_accept");
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset");
        for (int k = 0; k < 2; k++) check_eq("reset_mul_start", mul_start[k], 0);

        va[0] = 3; vb[0] = -5;
        send_vec(1, 1'b0, 0);

        for (int i = 0; i < 4; i++) begin va[i] = 127; vb[i] = 127; end
        send_vec(4, 1'b0, -1);

        for (int i = 0; i < 3; i++) begin va[i] = 127; vb[i] = 127; end
        send_vec(3, 1'b0, -1);
        for (int i = 0; i < 3; i++) begin va[i] = -128; vb[i] = 127; end
        send_vec(3, 1'b0, -1);

        for (int i = 0; i < 3; i++) begin va[i] = -128; vb[i] = -128; end
        send_vec(3, 1'b0, 5);
        va[0] = 2; vb[0] = 2;
        send_vec(1, 1'b0, 0);

        // Reset while the multiplier is busy; its late ready must not leak into the next vector.
        @(negedge clk);
        in_a = 8'd5; in_b = 8'd7; in_last = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle("mid_reset");
        for (int k = 0; k < 2; k++) begin
            check_eq("mid_reset_mul_start", mul_start[k], 0);
            check_eq("mid_reset_mul_a", mul_a[k], 0);
        end
        va[0] = -2; vb[0] = -64;
        send_vec(1, 1'b0, 0);

        va[0] = 9; vb[0] = 9;
        send_vec(1, 1'b1, 0);
        va[0] = 10; vb[0] = -3; va[1] = 50; vb[1] = 50;
        send_vec(2, 1'b1, -1);

        for (int v = 0; v < 20; v++) begin
            n = int'($urandom_range(1, 6));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    va[i] = ($urandom_range(0, 1) != 0) ? 127 : -128;
                    vb[i] = ($urandom_range(0, 1) != 0) ? 127 : -128;
                end else begin
                    va[i] = int'($urandom_range(0, 255)) - 128;
                    vb[i] = int'($urandom_range(0, 255)) - 128;
                end
            end
            send_vec(n, $urandom_range(0, 7) == 0, -1);
        end

        for (int i = 0; i < 257; i++) begin
            va[i] = int'($urandom_range(0, 255)) - 128;
            vb[i] = int'($urandom_range(0, 255)) - 128;
        end
        send_vec(257, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
